// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: FSM state type and width helper shared by scan_mux and its dwell counter
package scan_mux_pkg;
  typedef enum logic {MANUAL, SCAN} state_t;
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/scan_mux_dwell.sv
// scan_mux_dwell: dwell counter running 0..DWELL-1 while enabled, wrap flags the last count
module scan_mux_dwell
  import scan_mux_pkg::*;
#(
  parameter int DWELL = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic wrap
);
  localparam int BW = width_of(DWELL);
  logic [BW-1:0] cnt;
  assign wrap = enable && cnt == BW'(DWELL - 1);
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (enable) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered N-way channel mux with manual select and timed auto-scan; SCAN_MUX_PARITY_EN adds Par
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4,
  parameter int DWELL = 50000000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [N*W-1:0]         D,
  input  logic [width_of(N)-1:0] Sel,
  input  logic                   Scan,
  input  logic                   Hold,
  output logic [W-1:0]           Q,
  output logic [width_of(N)-1:0] Chan,
  output logic                   Tick
`ifdef SCAN_MUX_PARITY_EN
  ,
  output logic                   Par
`endif
);
  localparam int CW = width_of(N);
  state_t state, state_nxt;
  logic [CW-1:0] chan_nxt;
  logic [W-1:0] q_nxt;
  logic enable, clear, wrap, sel_ok;
  scan_mux_dwell #(.DWELL(DWELL)) u_dwell (
    .clk(Clock),
    .rst(Reset),
    .enable(enable),
    .clear(clear),
    .wrap(wrap)
  );
  assign sel_ok = {1'b0, Sel} < (CW + 1)'(N);
  assign q_nxt = D[chan_nxt*W +: W];
  always_comb begin
    state_nxt = Hold ? state : Scan ? SCAN : MANUAL;
    enable = !Hold && Scan && state == SCAN;
    clear = !Hold && !enable;
    chan_nxt = wrap ? ((Chan == CW'(N - 1)) ? '0 : Chan + 1'b1) :
               (!Hold && !Scan && sel_ok) ? Sel : Chan;
  end
  always_ff @(posedge Clock)
    if (Reset) begin
      state <= MANUAL;
      Chan <= '0;
      Q <= '0;
      Tick <= 1'b0;
    end else begin
      state <= state_nxt;
      Tick <= wrap;
      if (!Hold) begin
        Chan <= chan_nxt;
        Q <= q_nxt;
      end
    end
`ifdef SCAN_MUX_PARITY_EN
  always_ff @(posedge Clock)
    if (Reset) Par <= 1'b0;
    else if (!Hold) Par <= ^q_nxt;
`endif
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: scoreboard bench for scan_mux with an N=4/DWELL=3 and an N=3/DWELL=1 instance
module tb_scan_mux;
  localparam int W = 4, N = 4, DWELL = 3, CW = 2;
  typedef struct {
    logic [W-1:0]  q;
    logic [CW-1:0] chan;
    logic          tick;
    logic          par;
  } exp_t;
  logic clk = 1'b0;
  logic rst, scan, hold;
  logic [N*W-1:0] d;
  logic [CW-1:0] sel;
  logic [W-1:0] q;
  logic [CW-1:0] chan;
  logic tick;
  logic rst3, scan3, hold3;
  logic [3*W-1:0] d3;
  logic [1:0] sel3;
  logic [W-1:0] q3;
  logic [1:0] chan3;
  logic tick3;
`ifdef SCAN_MUX_PARITY_EN
  logic par, par3;
`endif
  exp_t sb[$], sb3[$], e, m;
  int checks = 0, errors = 0;
  bit m_scan;
  int m_cnt, m_chan;
  always #5 clk = ~clk;
  scan_mux #(.W(W), .N(N), .DWELL(DWELL)) dut (
    .Clock(clk), .Reset(rst), .D(d), .Sel(sel), .Scan(scan), .Hold(hold),
    .Q(q), .Chan(chan), .Tick(tick)
`ifdef SCAN_MUX_PARITY_EN
    , .Par(par)
`endif
  );
  scan_mux #(.W(W), .N(3), .DWELL(1)) dut3 (
    .Clock(clk), .Reset(rst3), .D(d3), .Sel(sel3), .Scan(scan3), .Hold(hold3),
    .Q(q3), .Chan(chan3), .Tick(tick3)
`ifdef SCAN_MUX_PARITY_EN
    , .Par(par3)
`endif
  );
  function automatic exp_t mk(input int qv, input int cv, input int tv);
    exp_t x;
    x.q = W'(qv);
    x.chan = CW'(cv);
    x.tick = 1'(tv);
    x.par = ^x.q;
    return x;
  endfunction
  task automatic step();
    if (rst) begin
      m_scan = 0;
      m_cnt = 0;
      m_chan = 0;
      m = mk(0, 0, 0);
    end else if (hold) m.tick = 1'b0;
    else begin
      m.tick = 1'b0;
      if (!scan) begin
        if (int'(sel) < N) m_chan = int'(sel);
        m_cnt = 0;
      end else if (!m_scan) m_cnt = 0;
      else if (m_cnt == DWELL - 1) begin
        m_cnt = 0;
        m_chan = (m_chan + 1) % N;
        m.tick = 1'b1;
      end else m_cnt++;
      m_scan = scan;
      m.chan = CW'(m_chan);
      m.q = d[m_chan*W +: W];
      m.par = ^m.q;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1; hold = 1; scan = 1; sel = 2'd3; d = 16'hFFFF;
    step();
    e = sb.pop_front();
    checks++;
    if (q !== e.q || chan !== e.chan || tick !== e.tick || q !== 4'h0 || chan !== 2'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL reset: got q=%h chan=%0d tick=%b want q=0 chan=0 tick=0", q, chan, tick);
    end
  endtask
  task automatic test_manual();
    int sels[5] = '{2, 0, 3, 1, 1};
    int qs[5] = '{3, 1, 4, 2, 5};
    rst = 0; hold = 0; scan = 0; d = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      sel = CW'(sels[i]);
      if (i == 4) d = 16'h4351;
      step();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || chan !== e.chan || tick !== e.tick || q !== W'(qs[i]) || chan !== CW'(sels[i]) || tick !== 1'b0) begin
        errors++;
        $display("FAIL manual[%0d]: got q=%h chan=%0d tick=%b want q=%h chan=%0d tick=0", i, q, chan, tick, qs[i], sels[i]);
      end
    end
  endtask
  task automatic test_scan();
    int seq[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    scan = 0; sel = 0; d = 16'h8765;
    step();
    void'(sb.pop_front());
    scan = 1;
    for (int i = 0; i < 13; i++) begin
      step();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || chan !== e.chan || tick !== e.tick || chan !== CW'(seq[i]) || q !== W'(5 + seq[i]) || tick !== 1'(i > 0 && i % 3 == 0)) begin
        errors++;
        $display("FAIL scan[%0d]: got q=%h chan=%0d tick=%b want q=%h chan=%0d tick=%b", i, q, chan, tick, 5 + seq[i], seq[i], i > 0 && i % 3 == 0);
      end
    end
  endtask
  task automatic test_hold();
    int seq[7] = '{1, 1, 1, 1, 1, 1, 2};
    scan = 0; sel = 1;
    step();
    scan = 1;
    step();
    step();
    repeat (3) void'(sb.pop_front());
    hold = 1; scan = 0; sel = 3; d = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        hold = 0; scan = 1; d = 16'h8765;
      end
      step();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || chan !== e.chan || tick !== e.tick || chan !== CW'(seq[i]) || q !== W'(5 + seq[i]) || tick !== 1'(i == 6)) begin
        errors++;
        $display("FAIL hold[%0d]: got q=%h chan=%0d tick=%b want q=%h chan=%0d tick=%b", i, q, chan, tick, 5 + seq[i], seq[i], i == 6);
      end
    end
  endtask
  task automatic test_reset_mid_scan();
    int seq[5] = '{0, 0, 0, 0, 1};
    repeat (4) step();
    repeat (4) void'(sb.pop_front());
    checks++;
    if (chan !== 2'd3) begin
      errors++;
      $display("FAIL pre_reset_chan: got chan=%0d want chan=3", chan);
    end
    for (int i = 0; i < 5; i++) begin
      rst = (i == 0);
      step();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || chan !== e.chan || tick !== e.tick || chan !== CW'(seq[i]) || tick !== 1'(i == 4) || (i == 0 && q !== 4'h0)) begin
        errors++;
        $display("FAIL reset_mid_scan[%0d]: got q=%h chan=%0d tick=%b want chan=%0d tick=%b", i, q, chan, tick, seq[i], i == 4);
      end
    end
  endtask
  task automatic test_back_to_back();
    int seq[6] = '{1, 3, 3, 3, 3, 0};
    sel = 3;
    for (int i = 0; i < 6; i++) begin
      scan = (i != 1);
      step();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || chan !== e.chan || tick !== e.tick || chan !== CW'(seq[i]) || tick !== 1'(i == 5)) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got q=%h chan=%0d tick=%b want chan=%0d tick=%b", i, q, chan, tick, seq[i], i == 5);
      end
    end
  endtask
`ifdef SCAN_MUX_PARITY_EN
  task automatic test_parity();
    logic pexp[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    scan = 0; sel = 0;
    for (int i = 0; i < 6; i++) begin
      d = (i == 1) ? 16'h0003 : 16'h000B;
      hold = (i >= 2 && i <= 4);
      step();
      e = sb.pop_front();
      checks++;
      if (par !== e.par || q !== e.q || par !== pexp[i]) begin
        errors++;
        $display("FAIL parity[%0d]: got par=%b q=%h want par=%b", i, par, q, pexp[i]);
      end
    end
    hold = 0;
  endtask
`endif
  task automatic test_dwell1();
    int seq[9] = '{0, 0, 1, 2, 0, 1, 1, 1, 2};
    d3 = 12'h987;
    for (int i = 0; i < 9; i++) begin
      rst3 = (i == 0);
      scan3 = (i < 6);
      sel3 = (i < 6) ? 2'd0 : (i < 8) ? 2'd3 : 2'd2;
      sb3.push_back(mk(i == 0 ? 0 : 7 + seq[i], seq[i], i >= 2 && i < 6));
      @(posedge clk);
      #1;
      e = sb3.pop_front();
      checks++;
      if (q3 !== e.q || chan3 !== e.chan || tick3 !== e.tick) begin
        errors++;
        $display("FAIL dwell1[%0d]: got q=%h chan=%0d tick=%b want q=%h chan=%0d tick=%b", i, q3, chan3, tick3, e.q, e.chan, e.tick);
      end
    end
  endtask
  initial begin
    rst3 = 1; scan3 = 0; hold3 = 0; sel3 = 0; d3 = '0;
    test_reset();
    test_manual();
    test_scan();
    test_hold();
    test_reset_mid_scan();
    test_back_to_back();
`ifdef SCAN_MUX_PARITY_EN
    test_parity();
`endif
    test_dwell1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
